// File: rtl/morpho_ctrl.sv
// morpho_ctrl: frame-synchronous mode commit, pixel position tracking and error flags
// for the dilate/erode pipeline. Define MORPHO_CTRL_STATS_EN to build the frame counter.
module morpho_ctrl #(
    parameter int LINE_LENGTH  = 800,
    parameter int FRAME_LINES  = 600,
    parameter int DRAIN_CYCLES = 2400,
    parameter int COL_W        = 10
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iLineValid,
    input  logic             iFrameValid,
    input  logic             iModeReq,
    input  logic [2:0]       iMode,
    input  logic             iErrClr,
    output logic             oModeAck,
    output logic             oModeBusy,
    output logic [2:0]       oSel,
    output logic             oBorder,
    output logic [COL_W-1:0] oCol,
    output logic [COL_W-1:0] oRow,
    output logic             oLenErr,
    output logic             oModeErr,
    output logic [15:0]      oFrameCnt,
    output logic [1:0]       oState
);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_FRAME = 2'd2,
        S_DRAIN = 2'd3
    } stateT;

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(LINE_LENGTH - 1);
    localparam logic [COL_W-1:0]   ROW_LAST   = COL_W'(FRAME_LINES - 1);
    localparam logic [COL_W:0]     LINE_FULL  = (COL_W + 1)'(LINE_LENGTH);

    stateT               stateQ;
    stateT               stateD;
    logic [DRAIN_W-1:0]  drainQ;
    logic [DRAIN_W-1:0]  drainD;
    logic                commit;
    logic                frameStart;
    logic                frameEnd;

    logic                lvPrevQ;
    logic                lvRise;
    logic                lvFall;
    logic                tracking;
    logic                lenBad;
    logic [COL_W-1:0]    colQ;
    logic [COL_W-1:0]    rowQ;

    logic                modeLegal;
    logic                reqLegal;
    logic                reqIllegal;
    logic [2:0]          pendQ;
    logic [2:0]          selQ;
    logic                busyQ;
    logic                ackQ;
    logic                lenErrQ;
    logic                modeErrQ;

    // Request handshake: iModeReq is a one-cycle strobe with no back-pressure. A legal
    // request is always taken (overwriting any pending one) and answered by oModeAck one
    // cycle later; oModeBusy stays high until the pending mode is committed to oSel.
    assign modeLegal  = (iMode <= 3'd4);
    assign reqLegal   = iModeReq & modeLegal;
    assign reqIllegal = iModeReq & ~modeLegal;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            stateQ <= S_WAIT;
            drainQ <= '0;
        end else begin
            stateQ <= stateD;
            drainQ <= drainD;
        end
    end

    always_comb begin
        stateD     = stateQ;
        drainD     = drainQ;
        commit     = 1'b0;
        frameStart = 1'b0;
        frameEnd   = 1'b0;
        case (stateQ)
            S_WAIT: begin
                if (!iFrameValid) begin
                    stateD = S_IDLE;
                end
            end
            S_IDLE: begin
                // Commit and frame start may share an edge; both take effect.
                commit = busyQ;
                if (iFrameValid) begin
                    stateD     = S_FRAME;
                    frameStart = 1'b1;
                end
            end
            S_FRAME: begin
                if (!iFrameValid) begin
                    stateD   = S_DRAIN;
                    drainD   = DRAIN_LOAD;
                    frameEnd = 1'b1;
                end
            end
            S_DRAIN: begin
                if (iFrameValid) begin
                    stateD     = S_FRAME;
                    frameStart = 1'b1;
                end else if (drainQ == '0) begin
                    stateD = S_IDLE;
                end else begin
                    drainD = drainQ - DRAIN_W'(1);
                end
            end
            default: begin
                stateD = S_WAIT;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            ackQ  <= 1'b0;
            busyQ <= 1'b0;
            pendQ <= '0;
            selQ  <= '0;
        end else begin
            ackQ <= reqLegal;
            if (reqLegal) begin
                pendQ <= iMode;
                busyQ <= 1'b1;
            end else if (commit) begin
                busyQ <= 1'b0;
            end
            if (commit) begin
                selQ <= pendQ;
            end
        end
    end

    // Position tracking runs only inside a frame, including the edge that starts it.
    assign tracking = (stateQ == S_FRAME) | frameStart;
    assign lvRise   = iLineValid & ~lvPrevQ;
    assign lvFall   = ~iLineValid & lvPrevQ;
    assign lenBad   = tracking & lvFall & (({1'b0, colQ} + (COL_W + 1)'(1)) != LINE_FULL);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            lvPrevQ <= 1'b0;
            colQ    <= '0;
            rowQ    <= '0;
        end else begin
            lvPrevQ <= iLineValid;
            if (tracking) begin
                if (lvRise) begin
                    colQ <= '0;
                end else if (iLineValid && iFrameValid && !(&colQ)) begin
                    colQ <= colQ + COL_W'(1);
                end
                if (frameStart) begin
                    rowQ <= '0;
                end else if (lvFall && !(&rowQ)) begin
                    rowQ <= rowQ + COL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            lenErrQ  <= 1'b0;
            modeErrQ <= 1'b0;
        end else begin
            lenErrQ  <= lenBad | (lenErrQ & ~iErrClr);
            modeErrQ <= reqIllegal | (modeErrQ & ~iErrClr);
        end
    end

`ifdef MORPHO_CTRL_STATS_EN
    logic [15:0] frameCntQ;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            frameCntQ <= '0;
        end else if (frameEnd) begin
            frameCntQ <= frameCntQ + 16'd1;
        end
    end

    assign oFrameCnt = frameCntQ;
`else
    assign oFrameCnt = 16'd0;
`endif

    // Border is gated by S_FRAME so a reset mid-frame never flags stale positions.
    assign oBorder = (stateQ == S_FRAME) & iLineValid & iFrameValid &
                     ((colQ == '0) | (colQ == COL_LAST) | (rowQ == '0) | (rowQ == ROW_LAST));

    assign oModeAck  = ackQ;
    assign oModeBusy = busyQ;
    assign oSel      = selQ;
    assign oCol      = colQ;
    assign oRow      = rowQ;
    assign oLenErr   = lenErrQ;
    assign oModeErr  = modeErrQ;
    assign oState    = stateQ;

endmodule
